// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared codes, widths and state type for the bus sequencer
package bus_pkg;

  localparam int SRC_W     = 3;
  localparam int DST_W     = 7;
  localparam int REG_SEL_W = 6;
  localparam int MEM_SEL_W = 2;
  localparam int WAIT_W    = 4;

  localparam logic [SRC_W-1:0] SRC_R    = 3'd0;
  localparam logic [SRC_W-1:0] SRC_AR   = 3'd1;
  localparam logic [SRC_W-1:0] SRC_DR   = 3'd2;
  localparam logic [SRC_W-1:0] SRC_AC   = 3'd3;
  localparam logic [SRC_W-1:0] SRC_PC   = 3'd4;
  localparam logic [SRC_W-1:0] SRC_IR   = 3'd5;
  localparam logic [SRC_W-1:0] SRC_DRAM = 3'd6;
  localparam logic [SRC_W-1:0] SRC_IRAM = 3'd7;

  localparam int DST_R    = 0;
  localparam int DST_AR   = 1;
  localparam int DST_DR   = 2;
  localparam int DST_AC   = 3;
  localparam int DST_PC   = 4;
  localparam int DST_IR   = 5;
  localparam int DST_DRAM = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_MWAIT,
    ST_LOAD
  } bus_state_t;

  function automatic logic is_mem_src(input logic [SRC_W-1:0] src);
    return (src == SRC_DRAM) || (src == SRC_IRAM);
  endfunction

  // A DRAM-to-DRAM move would need a read and a write in the same cycle.
  function automatic logic cmd_legal(input logic [SRC_W-1:0] src,
                                     input logic [DST_W-1:0] dst);
    return (dst != '0) && !((src == SRC_DRAM) && dst[DST_DRAM]);
  endfunction

  function automatic logic [REG_SEL_W+MEM_SEL_W-1:0] src_onehot(input logic [SRC_W-1:0] src);
    logic [REG_SEL_W+MEM_SEL_W-1:0] oh;
    oh = '0;
    oh[src] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - command handshake and bus-control signals of the sequencer
interface bus_sequencer_if #(
  parameter int CNT_W = 16
) ();
  import bus_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SRC_W-1:0]     cmd_src;
  logic [DST_W-1:0]     cmd_dst;
  logic [REG_SEL_W-1:0] control_register;
  logic [MEM_SEL_W-1:0] control_memory;
  logic [REG_SEL_W-1:0] ld;
  logic                 dram_we;
  logic                 mem_rd;
  logic                 done;
  logic                 err;
  logic                 busy;
  logic [CNT_W-1:0]     xfer_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, control_register, control_memory, ld, dram_we,
           mem_rd, done, err, busy, xfer_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, control_register, control_memory, ld, dram_we,
           mem_rd, done, err, busy, xfer_count
  );
endinterface

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - one-command-at-a-time data bus transfer sequencer
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_sequencer_if.slave bus
);

  localparam logic [WAIT_W-1:0] LAT_M1 = (MEM_LAT > 0) ? WAIT_W'(MEM_LAT - 1) : '0;

  bus_state_t           state;
  logic [SRC_W-1:0]     src_q;
  logic [DST_W-1:0]     dst_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cmd_ready_q;
  logic [REG_SEL_W-1:0] ctrl_reg_q;
  logic [MEM_SEL_W-1:0] ctrl_mem_q;
  logic [REG_SEL_W-1:0] ld_q;
  logic                 dram_we_q;
  logic                 mem_rd_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;
  logic [REG_SEL_W+MEM_SEL_W-1:0] sel_oh;

  assign sel_oh = src_onehot(bus.cmd_src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      wait_cnt    <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      ctrl_reg_q  <= '0;
      ctrl_mem_q  <= '0;
      ld_q        <= '0;
      dram_we_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ld_q      <= '0;
      dram_we_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Also re-opens the handshake after a rejected command's err cycle.
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && bus.cmd_valid) begin
            src_q       <= bus.cmd_src;
            dst_q       <= bus.cmd_dst;
            cmd_ready_q <= 1'b0;
            if (cmd_legal(bus.cmd_src, bus.cmd_dst)) begin
              state      <= ST_DRIVE;
              busy_q     <= 1'b1;
              ctrl_reg_q <= sel_oh[REG_SEL_W-1:0];
              ctrl_mem_q <= sel_oh[REG_SEL_W+MEM_SEL_W-1:REG_SEL_W];
              mem_rd_q   <= is_mem_src(bus.cmd_src);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (is_mem_src(src_q) && (MEM_LAT > 0)) begin
            state    <= ST_MWAIT;
            wait_cnt <= LAT_M1;
          end else begin
            state     <= ST_LOAD;
            ld_q      <= dst_q[REG_SEL_W-1:0];
            dram_we_q <= dst_q[DST_DRAM];
            done_q    <= 1'b1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        ST_MWAIT: begin
          if (wait_cnt == '0) begin
            state     <= ST_LOAD;
            ld_q      <= dst_q[REG_SEL_W-1:0];
            dram_we_q <= dst_q[DST_DRAM];
            done_q    <= 1'b1;
            cnt_q     <= cnt_q + CNT_W'(1);
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_LOAD: begin
          state       <= ST_IDLE;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          ctrl_reg_q  <= '0;
          ctrl_mem_q  <= '0;
          mem_rd_q    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.control_register = ctrl_reg_q;
  assign bus.control_memory   = ctrl_mem_q;
  assign bus.ld               = ld_q;
  assign bus.dram_we          = dram_we_q;
  assign bus.mem_rd           = mem_rd_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.busy             = busy_q;
  assign bus.xfer_count       = cnt_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed self-checking bench for bus_sequencer
module tb_bus_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bus_sequencer_if #(.CNT_W(16)) bus_a ();
  bus_sequencer_if #(.CNT_W(4))  bus_b ();

  bus_sequencer #(.MEM_LAT(2), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  bus_sequencer #(.MEM_LAT(0), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_src = '0; bus_a.cmd_dst = '0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_src = '0; bus_b.cmd_dst = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst_ready", bus_a.cmd_ready, 1);
    chk("rst_busy",  bus_a.busy, 0);
    chk("rst_sel",   {bus_a.control_register, bus_a.control_memory}, 0);
    chk("rst_count", bus_a.xfer_count, 0);

    // AC -> AR
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 3'd3; bus_a.cmd_dst = 7'b0000010;
    tick();
    bus_a.cmd_valid = 1'b0;
    chk("ac_n1_sel",   bus_a.control_register, 6'b001000);
    chk("ac_n1_done",  bus_a.done, 0);
    chk("ac_n1_ready", bus_a.cmd_ready, 0);
    chk("ac_n1_busy",  bus_a.busy, 1);
    tick();
    chk("ac_n2_sel",   bus_a.control_register, 6'b001000);
    chk("ac_n2_ld",    bus_a.ld, 6'b000010);
    chk("ac_n2_done",  bus_a.done, 1);
    chk("ac_n2_count", bus_a.xfer_count, 1);
    tick();
    chk("ac_n3_sel",   bus_a.control_register, 0);
    chk("ac_n3_ready", bus_a.cmd_ready, 1);
    chk("ac_n3_ld",    bus_a.ld, 0);

    // DRAM -> DR, MEM_LAT=2, valid held high
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 3'd6; bus_a.cmd_dst = 7'b0000100;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("dram_n%0d_sel", c), bus_a.control_memory, 2'b01);
      chk($sformatf("dram_n%0d_rd", c), bus_a.mem_rd, 1);
      chk($sformatf("dram_n%0d_done", c), bus_a.done, (c == 4) ? 1 : 0);
      chk($sformatf("dram_n%0d_ld", c), bus_a.ld, (c == 4) ? 6'b000100 : 6'b0);
      tick();
    end
    chk("dram_n5_ready", bus_a.cmd_ready, 1);
    chk("dram_n5_busy",  bus_a.busy, 0);
    tick();
    chk("dram_n6_busy",  bus_a.busy, 1);
    chk("dram_n6_sel",   bus_a.control_memory, 2'b01);
    bus_a.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus_a.done) seen = 1'b1;
      else tick();
    end
    chk("dram2_done_seen", seen, 1);
    chk("dram2_count", bus_a.xfer_count, 3);
    tick();

    // illegal: empty destination
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 3'd1; bus_a.cmd_dst = 7'b0;
    tick();
    chk("ill0_err",   bus_a.err, 1);
    chk("ill0_ready", bus_a.cmd_ready, 0);
    chk("ill0_sel",   {bus_a.control_register, bus_a.control_memory}, 0);
    chk("ill0_busy",  bus_a.busy, 0);
    bus_a.cmd_src = 3'd6; bus_a.cmd_dst = 7'b1000000;
    tick();
    chk("ill0_n2_err",   bus_a.err, 0);
    chk("ill0_n2_ready", bus_a.cmd_ready, 1);
    // illegal: DRAM to DRAM, accepted at N+2 of the previous reject
    tick();
    bus_a.cmd_valid = 1'b0;
    chk("ill1_err",   bus_a.err, 1);
    chk("ill1_sel",   {bus_a.control_register, bus_a.control_memory}, 0);
    chk("ill1_rd",    bus_a.mem_rd, 0);
    tick();
    chk("ill_count",  bus_a.xfer_count, 3);
    chk("ill_done",   bus_a.done, 0);

    // R -> R plus DRAM write
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 3'd0; bus_a.cmd_dst = 7'b1000001;
    tick();
    bus_a.cmd_valid = 1'b0;
    chk("rr_sel", bus_a.control_register, 6'b000001);
    tick();
    chk("rr_ld",  bus_a.ld, 6'b000001);
    chk("rr_we",  bus_a.dram_we, 1);
    chk("rr_count", bus_a.xfer_count, 4);
    tick();
    chk("rr_we_off", bus_a.dram_we, 0);

    // IRAM -> IR+R on the zero-latency instance, inputs scrambled while busy
    bus_b.cmd_valid = 1'b1; bus_b.cmd_src = 3'd7; bus_b.cmd_dst = 7'b0100001;
    tick();
    bus_b.cmd_valid = 1'b0; bus_b.cmd_src = 3'd0; bus_b.cmd_dst = 7'b0000010;
    chk("iram_n1_mem", bus_b.control_memory, 2'b10);
    chk("iram_n1_reg", bus_b.control_register, 0);
    chk("iram_n1_rd",  bus_b.mem_rd, 1);
    tick();
    chk("iram_n2_mem",  bus_b.control_memory, 2'b10);
    chk("iram_n2_ld",   bus_b.ld, 6'b100001);
    chk("iram_n2_done", bus_b.done, 1);
    chk("iram_count",   bus_b.xfer_count, 1);
    tick();

    // wrap the 4-bit counter
    for (int i = 0; i < 15; i++) begin
      bus_b.cmd_valid = 1'b1;
      bus_b.cmd_src = 3'(i % 6);
      bus_b.cmd_dst = 7'(1 << (i % 6));
      tick();
      bus_b.cmd_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        tick();
        if (bus_b.done) seen = 1'b1;
      end
      chk($sformatf("wrap%0d_done", i), seen, 1);
      chk($sformatf("wrap%0d_count", i), bus_b.xfer_count, 32'((i + 2) % 16));
      tick();
    end
    chk("wrap_final", bus_b.xfer_count, 0);

    // reset during MWAIT
    bus_a.cmd_valid = 1'b1; bus_a.cmd_src = 3'd6; bus_a.cmd_dst = 7'b0001000;
    tick();
    bus_a.cmd_valid = 1'b0;
    tick();
    chk("mw_busy", bus_a.busy, 1);
    chk("mw_rd",   bus_a.mem_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mwrst_sel",   bus_a.control_memory, 0);
    chk("mwrst_rd",    bus_a.mem_rd, 0);
    chk("mwrst_busy",  bus_a.busy, 0);
    chk("mwrst_count", bus_a.xfer_count, 0);
    chk("mwrst_ld",    bus_a.ld, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus_a.done) seen = 1'b1;
    end
    chk("mwrst_no_done", seen, 0);
    chk("mwrst_ready",   bus_a.cmd_ready, 1);
    chk("mwrst_count2",  bus_a.xfer_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
